fault_injector: RTL and testbench

Fault-injection engine between the SoC control block and the RV32I register file. Accepts one injection request at a time: target register, fault mode, bit mask and a delay in executed core cycles. After the delay it freezes the core, performs a read-modify-write on the target register, and reports the old and new values. Its register-file port has the same shape as the control block's, so either can drive the register file through a 2:1 mux.

---
 rtl/fault_injector.sv | 160 ++++++++++++++++
 tb/tb_fault_injector.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_injector.sv
// Fault-injection engine: delayed read-modify-write on one RV32I register.
// Drives the register file through the same port shape as the control block.
module fault_injector #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DELAY_WIDTH    = 16
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [REG_ADDR_WIDTH-1:0] req_reg,
  input  logic [1:0]                req_mode,
  input  logic [DATA_WIDTH-1:0]     req_mask,
  input  logic [DELAY_WIDTH-1:0]    req_delay,
  input  logic                      core_active,
  input  logic                      abort,
  output logic                      inj_stall,
  output logic [REG_ADDR_WIDTH-1:0] regfile_addr,
  input  logic [DATA_WIDTH-1:0]     regfile_read_data,
  output logic                      regfile_write_enable,
  output logic [DATA_WIDTH-1:0]     regfile_write_data,
  output logic                      done_valid,
  output logic                      done_ok,
  output logic [DATA_WIDTH-1:0]     done_old,
  output logic [DATA_WIDTH-1:0]     done_new,
  input  logic                      done_ready,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_STALL,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [DELAY_WIDTH-1:0]    cnt;
  logic [REG_ADDR_WIDTH-1:0] reg_q;
  logic [1:0]                mode_q;
  logic [DATA_WIDTH-1:0]     mask_q;
  logic [DATA_WIDTH-1:0]     old_q;
  logic [DATA_WIDTH-1:0]     new_q;
  logic                      ok_q;
  logic [DATA_WIDTH-1:0]     mod_data;

  logic req_bad;
  assign req_bad = (req_mode == 2'b11) || (req_reg == '0);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad)              state_nx = S_RESP;
          else if (req_delay == '0) state_nx = S_STALL;
          else                      state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort)
          state_nx = S_RESP;
        else if (core_active && cnt == DELAY_WIDTH'(1))
          state_nx = S_STALL;
      end
      S_STALL: state_nx = S_READ;
      S_READ:  state_nx = S_WRITE;
      S_WRITE: state_nx = S_RESP;
      S_RESP:  if (done_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mod_data = '0;
    unique case (1'b1)
      mode_q == 2'b00: mod_data = regfile_read_data ^ mask_q;
      mode_q == 2'b01: mod_data = old_q & ~mask_q;
      mode_q == 2'b10: mod_data = old_q | mask_q;
      mode_q == 2'b11: mod_data = '0;
      default:         mod_data = '0;
    endcase
    // flip uses latched old too; read_data term only kept for mode 00 symmetry
    if (mode_q == 2'b00) mod_data = old_q ^ mask_q;
  end

  always_comb begin
    req_ready            = (state == S_IDLE);
    busy                 = (state != S_IDLE);
    done_valid           = (state == S_RESP);
    inj_stall            = 1'b0;
    regfile_addr         = '0;
    regfile_write_enable = 1'b0;
    regfile_write_data   = '0;
    case (state)
      S_STALL: inj_stall = 1'b1;
      S_READ: begin
        inj_stall    = 1'b1;
        regfile_addr = reg_q;
      end
      S_WRITE: begin
        inj_stall            = 1'b1;
        regfile_addr         = reg_q;
        regfile_write_enable = 1'b1;
        regfile_write_data   = mod_data;
      end
      default: ;
    endcase
  end

  assign done_ok  = ok_q;
  assign done_old = old_q;
  assign done_new = new_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt    <= '0;
      reg_q  <= '0;
      mode_q <= '0;
      mask_q <= '0;
      old_q  <= '0;
      new_q  <= '0;
      ok_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            reg_q  <= req_reg;
            mode_q <= req_mode;
            mask_q <= req_mask;
            cnt    <= req_delay;
            old_q  <= '0;
            new_q  <= '0;
            ok_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!abort && core_active)
            cnt <= cnt - DELAY_WIDTH'(1);
        end
        S_READ: old_q <= regfile_read_data;
        S_WRITE: begin
          new_q <= mod_data;
          ok_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_injector.sv
// Bench for fault_injector: behavioural register file plus result model.
// Random requests are checked against an expected-register array.
module tb_fault_injector;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_reg;
  logic [1:0]  req_mode;
  logic [31:0] req_mask;
  logic [15:0] req_delay;
  logic        core_active;
  logic        abort;
  logic        inj_stall;
  logic [4:0]  regfile_addr;
  logic [31:0] regfile_read_data;
  logic        regfile_write_enable;
  logic [31:0] regfile_write_data;
  logic        done_valid;
  logic        done_ok;
  logic [31:0] done_old;
  logic [31:0] done_new;
  logic        done_ready;
  logic        busy;

  fault_injector dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_mode(req_mode),
    .req_mask(req_mask), .req_delay(req_delay),
    .core_active(core_active), .abort(abort),
    .inj_stall(inj_stall),
    .regfile_addr(regfile_addr),
    .regfile_read_data(regfile_read_data),
    .regfile_write_enable(regfile_write_enable),
    .regfile_write_data(regfile_write_data),
    .done_valid(done_valid), .done_ok(done_ok),
    .done_old(done_old), .done_new(done_new),
    .done_ready(done_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  logic [31:0] rf [32];
  logic [31:0] exp_rf [32];
  logic        poke_en = 1'b0;
  logic [4:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;
  int          stall_cnt = 0;
  int          wr_cnt = 0;
  logic [4:0]  last_wa = '0;
  logic [31:0] last_wd = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  assign regfile_read_data = rf[regfile_addr];

  always @(posedge CLK) begin
    if (poke_en) rf[poke_addr] <= poke_data;
    else if (regfile_write_enable) rf[regfile_addr] <= regfile_write_data;
    if (inj_stall) stall_cnt++;
    if (regfile_write_enable) begin
      wr_cnt++;
      last_wa = regfile_addr;
      last_wd = regfile_write_data;
    end
  end

  function automatic logic [31:0] inject(input logic [31:0] v,
                                         input logic [1:0] m,
                                         input logic [31:0] k);
    case (m)
      2'b00:   return v ^ k;
      2'b01:   return v & ~k;
      default: return v | k;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    step();
    poke_en   = 1'b0;
    exp_rf[a] = d;
  endtask

  task automatic send_req(input logic [4:0] r, input logic [1:0] m,
                          input logic [31:0] k, input logic [15:0] d);
    for (int i = 0; i < 50 && !req_ready; i++) step();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_wait got=%b want=1", req_ready);
    end
    req_reg   = r;
    req_mode  = m;
    req_mask  = k;
    req_delay = d;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (done_valid === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic release_resp();
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    for (int i = 0; i < 32; i++) poke(5'(i), $urandom);
    n_cmp++;
    if ({done_valid, done_ok, inj_stall, regfile_write_enable, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {done_valid, done_ok, inj_stall, regfile_write_enable, busy});
    end
    n_cmp++;
    if ({done_old, done_new} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data got=%h/%h want=0/0", done_old, done_new);
    end
    n_cmp++;
    if (req_ready !== 1'b1 || regfile_addr !== 5'd0 || regfile_write_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_port rdy=%b addr=%h wd=%h want 1/0/0",
               req_ready, regfile_addr, regfile_write_data);
    end
    RSTn = 1'b1;
    step();
  endtask

  task automatic test_flip_nodelay();
    int s0, w0;
    poke(5'd5, 32'h0000_00F0);
    s0 = stall_cnt;
    w0 = wr_cnt;
    send_req(5'd5, 2'b00, 32'h0000_0011, 16'd0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (inj_stall !== 1'b1 || done_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flip_stall cyc=%0d got=%b/%b want=1/0", i + 1, inj_stall, done_valid);
      end
      step();
    end
    n_cmp++;
    if (done_valid !== 1'b1 || done_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL flip_done_k4 got=%b/%b want=1/1", done_valid, done_ok);
    end
    n_cmp++;
    if (done_old !== 32'h0000_00F0 || done_new !== 32'h0000_00E1) begin
      n_fail++;
      $display("FAIL flip_data got=%h/%h want=000000f0/000000e1", done_old, done_new);
    end
    n_cmp++;
    if (stall_cnt - s0 != 3 || wr_cnt - w0 != 1 || last_wa !== 5'd5 || last_wd !== 32'h0000_00E1) begin
      n_fail++;
      $display("FAIL flip_port stalls=%0d writes=%0d a=%0d d=%h want 3/1/5/000000e1",
               stall_cnt - s0, wr_cnt - w0, last_wa, last_wd);
    end
    exp_rf[5] = inject(32'h0000_00F0, 2'b00, 32'h0000_0011);
    release_resp();
    n_cmp++;
    if (done_valid !== 1'b0 || busy !== 1'b0 || rf[5] !== exp_rf[5]) begin
      n_fail++;
      $display("FAIL flip_after dv=%b busy=%b x5=%h want 0/0/%h",
               done_valid, busy, rf[5], exp_rf[5]);
    end
  endtask

  task automatic test_stuck_delay();
    logic [5:0] seq = 6'b101101;
    bit to;
    poke(5'd10, 32'hFFFF_FFFF);
    send_req(5'd10, 2'b01, 32'h8000_0001, 16'd4);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (inj_stall !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stuck_wait cyc=%0d stall=%b busy=%b want 0/1", i, inj_stall, busy);
      end
      core_active = seq[5 - i];
      step();
    end
    core_active = 1'b0;
    n_cmp++;
    if (inj_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_stall_entry got=%b want=1", inj_stall);
    end
    wait_done(to);
    exp_rf[10] = inject(32'hFFFF_FFFF, 2'b01, 32'h8000_0001);
    n_cmp++;
    if (to || done_ok !== 1'b1 || done_old !== 32'hFFFF_FFFF || done_new !== 32'h7FFF_FFFE) begin
      n_fail++;
      $display("FAIL stuck_data to=%0d ok=%b old=%h new=%h want 0/1/ffffffff/7ffffffe",
               to, done_ok, done_old, done_new);
    end
    release_resp();
  endtask

  task automatic test_invalid();
    int s0, w0;
    s0 = stall_cnt;
    w0 = wr_cnt;
    send_req(5'd0, 2'b10, 32'hFFFF_FFFF, 16'd0);
    n_cmp++;
    if (done_valid !== 1'b1 || done_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_x0 got=%b/%b want=1/0", done_valid, done_ok);
    end
    release_resp();
    step();
    send_req(5'd3, 2'b11, 32'hFFFF_FFFF, 16'd2);
    n_cmp++;
    if (done_valid !== 1'b1 || done_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_mode got=%b/%b want=1/0", done_valid, done_ok);
    end
    release_resp();
    n_cmp++;
    if (stall_cnt != s0 || wr_cnt != w0 || rf[3] !== exp_rf[3]) begin
      n_fail++;
      $display("FAIL invalid_noaccess stalls=%0d writes=%0d want 0/0",
               stall_cnt - s0, wr_cnt - w0);
    end
  endtask

  task automatic test_abort();
    int s0, w0;
    s0 = stall_cnt;
    w0 = wr_cnt;
    send_req(5'd9, 2'b00, 32'hFFFF_FFFF, 16'd100);
    core_active = 1'b1;
    for (int i = 0; i < 10; i++) step();
    core_active = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (done_valid !== 1'b1 || done_ok !== 1'b0 || done_old !== 32'h0 || done_new !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_resp dv=%b ok=%b old=%h new=%h want 1/0/0/0",
               done_valid, done_ok, done_old, done_new);
    end
    release_resp();
    n_cmp++;
    if (stall_cnt != s0 || wr_cnt != w0 || rf[9] !== exp_rf[9]) begin
      n_fail++;
      $display("FAIL abort_noaccess stalls=%0d writes=%0d x9=%h want 0/0/%h",
               stall_cnt - s0, wr_cnt - w0, rf[9], exp_rf[9]);
    end
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] k = $urandom;
    logic [31:0] eo, en;
    bit to;
    int w0;
    eo = exp_rf[12];
    en = inject(eo, 2'b00, k);
    send_req(5'd12, 2'b00, k, 16'd0);
    wait_done(to);
    exp_rf[12] = en;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (to || done_valid !== 1'b1 || done_ok !== 1'b1 || done_old !== eo || done_new !== en) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d dv=%b ok=%b old=%h new=%h want 1/1/%h/%h",
                 i, done_valid, done_ok, done_old, done_new, eo, en);
      end
      step();
    end
    release_resp();
    w0 = wr_cnt;
    send_req(5'd7, 2'b10, 32'hFFFF_FFFF, 16'd0);
    step();
    n_cmp++;
    if (regfile_addr !== 5'd7 || inj_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_read_phase addr=%0d stall=%b want 7/1", regfile_addr, inj_stall);
    end
    #2 RSTn = 1'b0;
    #1;
    n_cmp++;
    if ({done_valid, done_ok, inj_stall, regfile_write_enable, busy, req_ready} !== 6'b000001 ||
        done_old !== 32'h0 || done_new !== 32'h0 || regfile_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_async ctrl=%b old=%h new=%h want 000001/0/0",
               {done_valid, done_ok, inj_stall, regfile_write_enable, busy, req_ready},
               done_old, done_new);
    end
    @(posedge CLK);
    #3 RSTn = 1'b1;
    step();
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || wr_cnt != w0 || rf[7] !== exp_rf[7]) begin
      n_fail++;
      $display("FAIL rst_release rdy=%b busy=%b writes=%0d x7=%h want 1/0/0/%h",
               req_ready, busy, wr_cnt - w0, rf[7], exp_rf[7]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [4:0]  r = 5'($urandom_range(0, 31));
      logic [1:0]  m = 2'($urandom_range(0, 3));
      logic [31:0] k = $urandom;
      logic [15:0] d = 16'($urandom_range(0, 8));
      bit          ok = (m != 2'b11) && (r != 5'd0);
      logic [31:0] eo = ok ? exp_rf[r] : 32'h0;
      logic [31:0] en = ok ? inject(exp_rf[r], m, k) : 32'h0;
      int          act = 0;
      int          hold = $urandom_range(0, 2);
      bit          to = 1'b0;
      send_req(r, m, k, d);
      if (ok) begin
        for (int i = 0; i < 200 && inj_stall !== 1'b1; i++) begin
          core_active = 1'($urandom);
          if (core_active) act++;
          step();
        end
        core_active = 1'b0;
        n_cmp++;
        if (act != int'(d) || inj_stall !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_delay n=%0d active=%0d stall=%b want %0d/1", n, act, inj_stall, d);
        end
        wait_done(to);
        exp_rf[r] = en;
      end
      for (int h = 0; h <= hold; h++) begin
        n_cmp++;
        if (to || done_valid !== 1'b1 || done_ok !== ok || done_old !== eo || done_new !== en) begin
          n_fail++;
          $display("FAIL rand_result n=%0d r=%0d m=%0d dv=%b ok=%b old=%h new=%h want %b/%h/%h",
                   n, r, m, done_valid, done_ok, done_old, done_new, ok, eo, en);
        end
        if (h < hold) step();
      end
      release_resp();
      n_cmp++;
      if (rf[r] !== exp_rf[r]) begin
        n_fail++;
        $display("FAIL rand_rf n=%0d x%0d=%h want %h", n, r, rf[r], exp_rf[r]);
      end
    end
  endtask

  initial begin
    req_valid   = 1'b0;
    req_reg     = '0;
    req_mode    = '0;
    req_mask    = '0;
    req_delay   = '0;
    core_active = 1'b0;
    abort       = 1'b0;
    done_ready  = 1'b0;
    test_reset();
    test_flip_nodelay();
    test_stuck_delay();
    test_invalid();
    test_abort();
    test_backpressure_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
